// File: rtl/keypad_scanner.sv
// Column-scan controller for a 4x4 active-low matrix keypad: walks the columns,
// samples the debounced rows at the end of each dwell and reports one strobe per press.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 70000,
  parameter int RELEASE_CYCLES = 70000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_CYCLES > RELEASE_CYCLES) ? SCAN_CYCLES : RELEASE_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    col_r, col_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    key_code_r, key_code_s;
  logic          key_valid_r, key_valid_s;
  logic          key_held_r;
  logic [3:0]    col_n_r;

  // Lower row index wins when several rows are pulled low together.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (rows[0] == 1'b0) begin
      idx = 2'd0;
    end else if (rows[1] == 1'b0) begin
      idx = 2'd1;
    end else if (rows[2] == 1'b0) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Next-state, counter, column and strobe logic for the scan/hold FSM.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    cnt_s       = cnt_r;
    key_code_s  = key_code_r;
    key_valid_s = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (cnt_r == SCAN_LAST) begin
          cnt_s = CNT_ZERO;
          if (row_n == 4'hF) begin
            col_s = col_r + 2'd1;
          end else begin
            key_code_s  = {lowest_low_row(row_n), col_r};
            key_valid_s = 1'b1;
            state_s     = ST_HELD;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (row_n != 4'hF) begin
          cnt_s = CNT_ZERO;
        end else if (cnt_r == REL_LAST) begin
          state_s = ST_SCAN;
          col_s   = col_r + 2'd1;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_SCAN;
        col_s   = 2'd0;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State register; outputs are registered from the next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_SCAN;
      col_r       <= 2'd0;
      cnt_r       <= CNT_ZERO;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
      col_n_r     <= 4'b1110;
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      cnt_r       <= cnt_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      key_held_r  <= (state_s == ST_HELD);
      col_n_r     <= ~(4'b0001 << col_s);
    end
  end

  assign col_n     = col_n_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, RELEASE_CYCLES=3 and a
// combinational keypad model driven by a 16-bit pressed-key mask (bit r*4+c).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  col_n;
    logic        valid;
    logic        held;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[$];

  keypad_scanner #(.SCAN_CYCLES(4), .RELEASE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its row to a column that is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [15:0] k, input logic [3:0] cn,
                              input logic v, input logic h, input logic [3:0] kc);
    vec_t t;
    t.keys = k; t.col_n = cn; t.valid = v; t.held = h; t.code = kc;
    return t;
  endfunction

  initial begin
    int strobes;
    logic [3:0] col_seq [4];
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

    // Idle scan: 16 edges, column advances every 4 edges and wraps.
    for (int e = 1; e <= 16; e++)
      vecs.push_back(mk(16'h0000, col_seq[(e / 4) % 4], 1'b0, 1'b0, 4'd0));
    // Press (2,1): column 1 selected at edge 20, sampled at edge 24.
    for (int e = 17; e <= 19; e++) vecs.push_back(mk(16'h0200, 4'b1110, 1'b0, 1'b0, 4'd0));
    for (int e = 20; e <= 23; e++) vecs.push_back(mk(16'h0200, 4'b1101, 1'b0, 1'b0, 4'd0));
    vecs.push_back(mk(16'h0200, 4'b1101, 1'b1, 1'b1, 4'd9));
    vecs.push_back(mk(16'h0200, 4'b1101, 1'b0, 1'b1, 4'd9));

    repeat (2) @(posedge clk);
    #1;
    check("reset_col_n", col_n, 4'b1110);
    check("reset_valid", key_valid, 1'b0);
    check("reset_held", key_held, 1'b0);
    check("reset_code", key_code, 4'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      keys = vecs[i].keys;
      step();
      check($sformatf("vec%0d_col_n", i), col_n, vecs[i].col_n);
      check($sformatf("vec%0d_valid", i), key_valid, vecs[i].valid);
      check($sformatf("vec%0d_held", i), key_held, vecs[i].held);
      check($sformatf("vec%0d_code", i), key_code, vecs[i].code);
    end

    // Long hold: no further strobes, column frozen.
    strobes = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (key_valid) strobes++;
    end
    check("hold_strobes", strobes, 0);
    check("hold_held", key_held, 1'b1);
    check("hold_col_n", col_n, 4'b1101);

    // Release with a 2-cycle glitch, then stable release.
    keys = 16'h0000; step(); step();
    check("glitch_held", key_held, 1'b1);
    keys = 16'h0200; step();
    keys = 16'h0000; step(); step();
    check("release_held_2", key_held, 1'b1);
    check("release_valid", key_valid, 1'b0);
    step();
    check("release_held_3", key_held, 1'b0);
    check("release_col_n", col_n, 4'b1011);
    check("release_code_kept", key_code, 4'd9);

    // Two keys in column 3: row 0 must win, exactly one strobe.
    keys = 16'h8008;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (key_valid) begin
        strobes++;
        check("multi_code", key_code, 4'd3);
      end
    end
    check("multi_strobes", strobes, 1);
    check("multi_col_n", col_n, 4'b0111);
    keys = 16'h0000;
    step(); step(); step();
    check("multi_release_held", key_held, 1'b0);
    check("multi_release_col_n", col_n, 4'b1110);

    // Short row pulse early in column 0 dwell is ignored.
    strobes = 0;
    keys = 16'h0010; step(); step();
    keys = 16'h0000; step(); step();
    if (key_valid) strobes++;
    check("pulse_strobes", strobes, 0);
    check("pulse_held", key_held, 1'b0);
    check("pulse_col_n", col_n, 4'b1101);

    // Enter HELD on (3,2), then async reset between edges.
    keys = 16'h4000;
    for (int i = 0; i < 30 && !key_held; i++) step();
    check("pre_reset_held", key_held, 1'b1);
    check("pre_reset_code", key_code, 4'd14);
    #2;
    rst = 1'b1;
    #1;
    check("async_col_n", col_n, 4'b1110);
    check("async_valid", key_valid, 1'b0);
    check("async_held", key_held, 1'b0);
    check("async_code", key_code, 4'd0);
    keys = 16'h0000;
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("restart%0d_col_n", e), col_n, (e < 4) ? 4'b1110 : 4'b1101);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
